// File: rtl/mu01_pkg.sv
// Shared MU01 definitions: bus widths, arbiter port indices, core opcodes and small helpers.
package mu01_pkg;

  localparam int AW_DEF = 12;
  localparam int DW_DEF = 16;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  localparam logic [3:0] OP_HLT = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STO = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_JZ  = 4'h6;

  // Tag of the access whose response is due in the next cycle.
  typedef struct packed {
    logic vld;
    logic port;
    logic rd;
  } rsp_tag_t;

  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] max);
    return (v >= max) ? max : v + 4'd1;
  endfunction

endpackage

// File: rtl/mu01_arb_pick.sv
// Two-port grant selection, combinational. Fixed priority with starvation promotion by default;
// MU01_ARB_RR_EN selects round-robin. A single valid requester is always granted.
module mu01_arb_pick
  import mu01_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_grant,
  input  logic [3:0] wait_cnt,
  output logic [1:0] grant,
  output logic [3:0] wait_cnt_nxt
);

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

`ifdef MU01_ARB_RR_EN
  logic [3:0] unused_wait;
  assign unused_wait = wait_cnt;

  always_comb begin
    grant = 2'b00;
    if (valid0 && valid1) begin
      grant = (last_grant == PORT_DMA) ? 2'b01 : 2'b10;
    end else if (valid0) begin
      grant = 2'b01;
    end else if (valid1) begin
      grant = 2'b10;
    end
  end

  assign wait_cnt_nxt = 4'd0;
`else
  logic unused_last;
  assign unused_last = last_grant;

  always_comb begin
    grant = 2'b00;
    if (valid0 && valid1) begin
      grant = (wait_cnt == MAX_W) ? 2'b10 : 2'b01;
    end else if (valid0) begin
      grant = 2'b01;
    end else if (valid1) begin
      grant = 2'b10;
    end
  end

  // Count only cycles in which port 1 is actually refused.
  always_comb begin
    wait_cnt_nxt = 4'd0;
    if (valid1 && !grant[1]) begin
      wait_cnt_nxt = sat_inc(wait_cnt, MAX_W);
    end
  end
`endif

endmodule

// File: rtl/mu01_mem_arbiter.sv
// Shares the single-port MU01 memory between core (port 0) and loader/DMA (port 1); ready is
// same-cycle, response one cycle after handshake. Policy in mu01_arb_pick (MU01_ARB_RR_EN = round-robin).
module mu01_mem_arbiter
  import mu01_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_rdata,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  logic [1:0] pick_gnt;
  logic [1:0] gnt;
  logic [3:0] wait_cnt;
  logic [3:0] wait_cnt_nxt;
  logic       last_grant;
  rsp_tag_t   pend;

  mu01_arb_pick #(
    .MAX_WAIT(MAX_WAIT)
  ) u_pick (
    .valid0      (req0_valid),
    .valid1      (req1_valid),
    .last_grant  (last_grant),
    .wait_cnt    (wait_cnt),
    .grant       (pick_gnt),
    .wait_cnt_nxt(wait_cnt_nxt)
  );

  // No grants while reset is held so every output reads 0.
  assign gnt        = reset ? 2'b00 : pick_gnt;
  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  always_comb begin
    mem_en    = |gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt[0]) begin
      mem_we    = req0_we;
      mem_addr  = req0_addr;
      mem_wdata = req0_wdata;
    end else if (gnt[1]) begin
      mem_we    = req1_we;
      mem_addr  = req1_addr;
      mem_wdata = req1_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend       <= '0;
      wait_cnt   <= 4'd0;
      last_grant <= PORT_DMA;
    end else begin
      pend.vld <= |gnt;
      pend.port <= gnt[1];
      pend.rd  <= ~mem_we;
      wait_cnt <= wait_cnt_nxt;
      if (|gnt) begin
        last_grant <= gnt[1];
      end
    end
  end

  assign rsp0_valid = pend.vld && (pend.port == PORT_CPU);
  assign rsp1_valid = pend.vld && (pend.port == PORT_DMA);
  assign rsp0_rdata = (rsp0_valid && pend.rd) ? mem_rdata : '0;
  assign rsp1_rdata = (rsp1_valid && pend.rd) ? mem_rdata : '0;

endmodule

// File: tb/tb_mu01_mem_arbiter.sv
// Directed bench for mu01_mem_arbiter: main instance MAX_WAIT=4 with a memory model, second instance MAX_WAIT=1.
module tb_mu01_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        preload;

  logic        req0_valid, req0_ready, req0_we;
  logic [11:0] req0_addr;
  logic [15:0] req0_wdata;
  logic        rsp0_valid;
  logic [15:0] rsp0_rdata;
  logic        req1_valid, req1_ready, req1_we;
  logic [11:0] req1_addr;
  logic [15:0] req1_wdata;
  logic        rsp1_valid;
  logic [15:0] rsp1_rdata;
  logic        mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic        w_req0_valid, w_req0_ready, w_req1_valid, w_req1_ready;
  logic        w_rsp0_valid, w_rsp1_valid, w_mem_en, w_mem_we;
  logic [15:0] w_rsp0_rdata, w_rsp1_rdata, w_mem_wdata;
  logic [11:0] w_mem_addr;

  logic [15:0] mem [0:4095];

  int total = 0;
  int bad   = 0;

`ifdef MU01_ARB_RR_EN
  int exp_g [12] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`else
  int exp_g [12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
`endif
  logic [1:0] exp_w [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preload) begin
      mem[12'h010] <= 16'h1234;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  mu01_mem_arbiter #(.AW(12), .DW(16), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mu01_mem_arbiter #(.AW(12), .DW(16), .MAX_WAIT(1)) dut_w1 (
    .clk(clk), .reset(reset),
    .req0_valid(w_req0_valid), .req0_ready(w_req0_ready), .req0_we(1'b0),
    .req0_addr(12'h001), .req0_wdata(16'h0000),
    .rsp0_valid(w_rsp0_valid), .rsp0_rdata(w_rsp0_rdata),
    .req1_valid(w_req1_valid), .req1_ready(w_req1_ready), .req1_we(1'b0),
    .req1_addr(12'h002), .req1_wdata(16'h0000),
    .rsp1_valid(w_rsp1_valid), .rsp1_rdata(w_rsp1_rdata),
    .mem_en(w_mem_en), .mem_we(w_mem_we), .mem_addr(w_mem_addr),
    .mem_wdata(w_mem_wdata), .mem_rdata(16'h0000)
  );

  task automatic drive_idle();
    req0_valid = 0; req0_we = 0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 0; req1_we = 0; req1_addr = '0; req1_wdata = '0;
    w_req0_valid = 0; w_req1_valid = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    drive_idle();
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic test_reset();
    logic [71:0] outs;
    req0_valid = 1; req1_valid = 1; w_req0_valid = 1; w_req1_valid = 1;
    @(negedge clk);
    outs = {req0_ready, req1_ready, mem_en, mem_we, mem_addr, mem_wdata,
            rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata};
    total++;
    if (outs !== 72'h0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0", outs);
    end
    total++;
    if ({w_req0_ready, w_req1_ready, w_mem_en, w_rsp0_valid, w_rsp1_valid} !== 5'b0) begin
      bad++; $display("FAIL reset_outputs_w1: got %b want 00000",
                      {w_req0_ready, w_req1_ready, w_mem_en, w_rsp0_valid, w_rsp1_valid});
    end
    @(posedge clk); #1;
    drive_idle();
    reset = 0; preload = 0;
  endtask

  task automatic test_single_read();
    req0_valid = 1; req0_we = 0; req0_addr = 12'h010;
    @(negedge clk);
    total++;
    if ({req0_ready, req1_ready, mem_en, mem_we, mem_addr} !== {4'b1010, 12'h010}) begin
      bad++; $display("FAIL read_grant: got r0=%b r1=%b en=%b we=%b addr=%h want 1 0 1 0 010",
                      req0_ready, req1_ready, mem_en, mem_we, mem_addr);
    end
    @(posedge clk); #1;
    drive_idle();
    total++;
    if ({rsp0_valid, rsp0_rdata, rsp1_valid} !== {1'b1, 16'h1234, 1'b0}) begin
      bad++; $display("FAIL read_rsp: got v0=%b d0=%h v1=%b want 1 1234 0",
                      rsp0_valid, rsp0_rdata, rsp1_valid);
    end
    @(posedge clk); #1;
    total++;
    if ({rsp0_valid, rsp1_valid, mem_en} !== 3'b000) begin
      bad++; $display("FAIL read_rsp_single_pulse: got %b want 000", {rsp0_valid, rsp1_valid, mem_en});
    end
  endtask

  task automatic test_write_then_read();
    req1_valid = 1; req1_we = 1; req1_addr = 12'h0FF; req1_wdata = 16'hBEEF;
    @(negedge clk);
    total++;
    if ({req0_ready, req1_ready, mem_en, mem_we, mem_addr, mem_wdata} !== {4'b0111, 12'h0FF, 16'hBEEF}) begin
      bad++; $display("FAIL write_grant: got r0=%b r1=%b en=%b we=%b addr=%h wd=%h want 0 1 1 1 0ff beef",
                      req0_ready, req1_ready, mem_en, mem_we, mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
    drive_idle();
    req0_valid = 1; req0_we = 0; req0_addr = 12'h0FF;
    total++;
    if ({rsp1_valid, rsp1_rdata, rsp0_valid} !== {1'b1, 16'h0000, 1'b0}) begin
      bad++; $display("FAIL write_rsp: got v1=%b d1=%h v0=%b want 1 0000 0",
                      rsp1_valid, rsp1_rdata, rsp0_valid);
    end
    @(negedge clk);
    total++;
    if ({req0_ready, req1_ready, mem_we} !== 3'b100) begin
      bad++; $display("FAIL readback_grant: got %b want 100", {req0_ready, req1_ready, mem_we});
    end
    @(posedge clk); #1;
    drive_idle();
    total++;
    if ({rsp0_valid, rsp0_rdata, rsp1_valid} !== {1'b1, 16'hBEEF, 1'b0}) begin
      bad++; $display("FAIL readback_rsp: got v0=%b d0=%h v1=%b want 1 beef 0",
                      rsp0_valid, rsp0_rdata, rsp1_valid);
    end
  endtask

  task automatic test_contention();
    int prev;
    logic [1:0] exp_rdy, exp_rsp;
    do_reset();
    req0_valid = 1; req0_addr = 12'h020;
    req1_valid = 1; req1_addr = 12'h030;
    prev = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      exp_rdy = (exp_g[i] == 1) ? 2'b10 : 2'b01;
      exp_rsp = (prev < 0) ? 2'b00 : ((prev == 1) ? 2'b10 : 2'b01);
      total++;
      if ({req1_ready, req0_ready} !== exp_rdy) begin
        bad++; $display("FAIL contention_grant[%0d]: got %b want %b", i, {req1_ready, req0_ready}, exp_rdy);
      end
      total++;
      if ({rsp1_valid, rsp0_valid} !== exp_rsp) begin
        bad++; $display("FAIL contention_rsp[%0d]: got %b want %b", i, {rsp1_valid, rsp0_valid}, exp_rsp);
      end
      prev = exp_g[i];
      @(posedge clk);
    end
    #1;
    drive_idle();
  endtask

  task automatic test_reset_mid();
    logic [71:0] outs;
    do_reset();
    req0_valid = 1; req0_we = 0; req0_addr = 12'h010;
    @(negedge clk);
    total++;
    if (req0_ready !== 1'b1) begin
      bad++; $display("FAIL midreset_handshake: got %b want 1", req0_ready);
    end
    #4;
    reset = 1;
    req1_valid = 1; req1_addr = 12'h040;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      outs = {req0_ready, req1_ready, mem_en, mem_we, mem_addr, mem_wdata,
              rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata};
      total++;
      if (outs !== 72'h0) begin
        bad++; $display("FAIL midreset_outputs[%0d]: got %h want 0", i, outs);
      end
      @(posedge clk);
    end
    #1;
    reset = 0;
    @(negedge clk);
    total++;
    if ({req1_ready, req0_ready, rsp0_valid, rsp1_valid} !== 4'b0100) begin
      bad++; $display("FAIL midreset_release: got r1r0=%b rsp0=%b rsp1=%b want 01 0 0",
                      {req1_ready, req0_ready}, rsp0_valid, rsp1_valid);
    end
    @(posedge clk); #1;
    drive_idle();
  endtask

  task automatic test_starve_w1();
    do_reset();
    w_req0_valid = 1; w_req1_valid = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if ({w_req1_ready, w_req0_ready} !== exp_w[i]) begin
        bad++; $display("FAIL starve_w1_grant[%0d]: got %b want %b", i, {w_req1_ready, w_req0_ready}, exp_w[i]);
      end
      @(posedge clk); #1;
    end
    drive_idle();
  endtask

  initial begin
    reset = 1; preload = 1;
    drive_idle();
    @(posedge clk);
    @(posedge clk); #1;
    test_reset();
    test_single_read();
    test_write_then_read();
    test_contention();
    test_reset_mid();
    test_starve_w1();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
